// File: rtl/icache_refill_unit_pkg.sv
// Shared definitions for the ICache refill path.
// The state encoding, AXI burst constants and the PhysAddr offset/index/tag
// split live here so the ICache and the refill unit slice addresses the same way.
package icache_refill_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RECV  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } refill_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [7:0] BURST_LEN8 = 8'd7;

  // PhysAddr[4:0] is the byte offset within a line, [11:5] the set index,
  // [31:12] the tag; [4:2] selects the 32-bit word inside the line.
  localparam int OFFSET_WIDE = 5;
  localparam int WORD_LSB    = 2;
  localparam int INDEX_LSB   = 5;
  localparam int TAG_LSB     = 12;

  localparam int         BEAT_CNT_WIDE = 3;
  localparam logic [2:0] LAST_BEAT     = 3'd7;

endpackage

// File: rtl/icache_refill_unit_line.sv
// icache_line_buffer: BEATNUM x BEATWIDE register file that collects the
// returned burst beats; one write port addressed by word slot and a flat
// read of the whole line (word i at bits [BEATWIDE*i +: BEATWIDE]).
module icache_line_buffer
  import icache_refill_unit_pkg::*;
#(
  parameter int BEATWIDE = 32,
  parameter int BEATNUM  = 8
) (
  input  logic                         Clk,
  input  logic                         Rest,
  input  logic                         Clear,
  input  logic                         WrEn,
  input  logic [BEAT_CNT_WIDE-1:0]     WrIdx,
  input  logic [BEATWIDE-1:0]          WrData,
  output logic [BEATWIDE*BEATNUM-1:0]  Line
);

  logic [BEATWIDE-1:0] words [BEATNUM];

  // Storage: cleared on reset and at the start of every miss so no word of
  // an earlier line can leak into the next one.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      for (int i = 0; i < BEATNUM; i++) words[i] <= '0;
    end else if (Clear) begin
      for (int i = 0; i < BEATNUM; i++) words[i] <= '0;
    end else if (WrEn) begin
      words[WrIdx] <= WrData;
    end
  end

  for (genvar g = 0; g < BEATNUM; g++) begin : g_flat
    assign Line[BEATWIDE*g +: BEATWIDE] = words[g];
  end

endmodule

// File: rtl/icache_refill_unit.sv
// icache_refill_unit: single-outstanding ICache miss handler. Issues one
// 8-beat AXI read burst, assembles the line and hands it back to the ICache.
// Optional build macro ICACHE_REFILL_CWF_EN enables critical-word-first:
// WRAP burst from the missing word, early CritValid/CritWord forwarding.
module icache_refill_unit
  import icache_refill_unit_pkg::*;
#(
  parameter int ADDRWIDE  = 32,
  parameter int BEATWIDE  = 32,
  parameter int BEATNUM   = 8,
  parameter int INDEXWIDE = 7,
  parameter int TAGWIDE   = 20
) (
  input  logic                         Clk,
  input  logic                         Rest,
  input  logic                         MissReq,
  input  logic [ADDRWIDE-1:0]          MissAddr,
  input  logic                         MissWay,
  input  logic                         CacheStateFluah,
  output logic                         RefillBusy,
  output logic                         ReadMAble,
  input  logic                         ReadMAck,
  output logic [ADDRWIDE-1:0]          ReadMAddr,
  output logic [7:0]                   ReadMlen,
  output logic [2:0]                   ReadMsize,
  output logic [1:0]                   ReadMBurstTy,
  input  logic                         MemoryAble,
  input  logic                         MemoryBrustAble,
  input  logic [BEATWIDE-1:0]          MemoryDate,
  output logic                         RefillValid,
  output logic [INDEXWIDE-1:0]         RefillIndex,
  output logic [TAGWIDE-1:0]           RefillTag,
  output logic                         RefillWay,
  output logic [BEATWIDE*BEATNUM-1:0]  RefillLine,
  output logic                         RefillErr
`ifdef ICACHE_REFILL_CWF_EN
  ,
  output logic                         CritValid,
  output logic [BEATWIDE-1:0]          CritWord
`endif
);

  refill_state_e              state;
  logic [BEAT_CNT_WIDE-1:0]   beatCnt;
  logic [BEAT_CNT_WIDE-1:0]   wrIdx;
  logic                       errPend;
  logic                       refillValidQ;
  logic                       acceptMiss;
  logic                       beatWr;
  logic [ADDRWIDE-1:0]        burstAddr;
  logic [1:0]                 burstType;
  logic                       unusedAddrBits;

  assign ReadMlen  = BURST_LEN8;
  assign ReadMsize = SIZE_4B;

  assign acceptMiss = (state == S_IDLE) && MissReq && !CacheStateFluah;
  assign beatWr     = (state == S_RECV) && MemoryAble && !CacheStateFluah;

  // A flush landing in the DONE cycle must still stop the SRAM write.
  assign RefillValid = refillValidQ && !CacheStateFluah;

`ifdef ICACHE_REFILL_CWF_EN
  logic [BEAT_CNT_WIDE-1:0] startSlot;
  assign burstAddr      = {MissAddr[ADDRWIDE-1:WORD_LSB], {WORD_LSB{1'b0}}};
  assign burstType      = BURST_WRAP;
  assign wrIdx          = startSlot + beatCnt;
  assign unusedAddrBits = ^MissAddr[WORD_LSB-1:0];
`else
  assign burstAddr      = {MissAddr[ADDRWIDE-1:OFFSET_WIDE], {OFFSET_WIDE{1'b0}}};
  assign burstType      = BURST_INCR;
  assign wrIdx          = beatCnt;
  assign unusedAddrBits = ^MissAddr[OFFSET_WIDE-1:0];
`endif

  icache_line_buffer #(
    .BEATWIDE (BEATWIDE),
    .BEATNUM  (BEATNUM)
  ) u_line (
    .Clk    (Clk),
    .Rest   (Rest),
    .Clear  (acceptMiss),
    .WrEn   (beatWr),
    .WrIdx  (wrIdx),
    .WrData (MemoryDate),
    .Line   (RefillLine)
  );

  // Refill FSM with registered AXI and ICache-side outputs. The AR request
  // goes out the cycle after the miss; a burst already accepted by the
  // bridge is always drained, since AXI offers no way to cancel it.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      state        <= S_IDLE;
      beatCnt      <= '0;
      errPend      <= 1'b0;
      refillValidQ <= 1'b0;
      RefillBusy   <= 1'b0;
      ReadMAble    <= 1'b0;
      ReadMAddr    <= '0;
      ReadMBurstTy <= '0;
      RefillIndex  <= '0;
      RefillTag    <= '0;
      RefillWay    <= 1'b0;
      RefillErr    <= 1'b0;
`ifdef ICACHE_REFILL_CWF_EN
      startSlot    <= '0;
      CritValid    <= 1'b0;
      CritWord     <= '0;
`endif
    end else begin
      RefillErr    <= 1'b0;
      refillValidQ <= 1'b0;
`ifdef ICACHE_REFILL_CWF_EN
      CritValid    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (acceptMiss) begin
            state        <= S_REQ;
            RefillBusy   <= 1'b1;
            ReadMAble    <= 1'b1;
            ReadMAddr    <= burstAddr;
            ReadMBurstTy <= burstType;
            RefillIndex  <= MissAddr[INDEX_LSB +: INDEXWIDE];
            RefillTag    <= MissAddr[TAG_LSB +: TAGWIDE];
            RefillWay    <= MissWay;
            beatCnt      <= '0;
            errPend      <= 1'b0;
`ifdef ICACHE_REFILL_CWF_EN
            startSlot    <= MissAddr[WORD_LSB +: BEAT_CNT_WIDE];
`endif
          end
        end
        S_REQ: begin
          if (ReadMAck) begin
            ReadMAble <= 1'b0;
            state     <= CacheStateFluah ? S_DRAIN : S_RECV;
          end else if (CacheStateFluah) begin
            ReadMAble  <= 1'b0;
            RefillBusy <= 1'b0;
            state      <= S_IDLE;
          end
        end
        S_RECV: begin
          if (CacheStateFluah) begin
            if (MemoryAble && MemoryBrustAble) begin
              RefillBusy <= 1'b0;
              state      <= S_IDLE;
            end else begin
              state <= S_DRAIN;
            end
          end else if (MemoryAble) begin
            beatCnt <= beatCnt + 1'b1;
`ifdef ICACHE_REFILL_CWF_EN
            CritValid <= (beatCnt == '0);
            if (beatCnt == '0) CritWord <= MemoryDate;
`endif
            if (MemoryBrustAble) begin
              if (beatCnt == LAST_BEAT) begin
                refillValidQ <= 1'b1;
                state        <= S_DONE;
              end else begin
                RefillErr  <= 1'b1;
                RefillBusy <= 1'b0;
                state      <= S_IDLE;
              end
            end else if (beatCnt == LAST_BEAT) begin
              errPend <= 1'b1;
              state   <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (MemoryAble && MemoryBrustAble) begin
            RefillErr  <= errPend;
            errPend    <= 1'b0;
            RefillBusy <= 1'b0;
            state      <= S_IDLE;
          end
        end
        S_DONE: begin
          RefillBusy <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          RefillBusy <= 1'b0;
          ReadMAble  <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
